mux_scan_reg: RTL and testbench

- Parametrised, registered N-channel, W-bit channel selector for the lab datapath.
- Supports two modes:
  - manual: channel chosen by `sl`.
  - auto-scan: channels visited round-robin, each for a fixed dwell time.
- Every channel change inserts a programmable blanking gap with output forced to zero. Downstream logic never sees a mixed or glitched sample.
- Sits between the input sources and the display/counter stages; downstream consumes `out` qualified by `valid`.

---
 rtl/mux_scan_reg_if.sv | 17 +
 rtl/mux_scan_reg.sv | 83 ++++++++
 tb/tb_mux_scan_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mux_scan_reg_if.sv
// mux_scan_reg_if: channel data, selection controls and registered outputs of the channel selector
interface mux_scan_reg_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] din;
    logic [SELW-1:0]      sl;
    logic                 mode;
    logic                 hold;
    logic [WIDTH-1:0]     out;
    logic [SELW-1:0]      out_ch;
    logic                 valid;
    logic                 sw_pulse;
    modport master (output din, sl, mode, hold, input out, out_ch, valid, sw_pulse);
    modport slave  (input din, sl, mode, hold, output out, out_ch, valid, sw_pulse);
endinterface

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-channel selector with manual/scan modes and zeroed blanking on channel change
module mux_scan_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 16,
    parameter int BLANK = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scan_reg_if.slave bus
);
    localparam int DW = $clog2(DWELL + 1);
    localparam int BW = $clog2(BLANK + 2);
    typedef enum logic {RUN, BLNK} state_t;
    state_t           state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [WIDTH-1:0] out_q, out_d, din_sel;
    logic [SELW-1:0]  ch_q, ch_d, sl_clamp, ch_next, target, sel_ch;
    logic             valid_q, valid_d, sw_q, sw_d, dwell_end, blank_end, do_sw;
    assign sl_clamp  = (int'(bus.sl) >= NCH) ? SELW'(NCH - 1) : bus.sl;
    assign ch_next   = (int'(ch_q) == NCH - 1) ? '0 : ch_q + SELW'(1);
    assign dwell_end = int'(dwell_q) == DWELL - 1;
    assign blank_end = int'(blank_q) == BLANK - 1;
    assign target    = bus.hold ? ch_q : !bus.mode ? sl_clamp : dwell_end ? ch_next : ch_q;
    assign do_sw     = (state_q == RUN) && (target != ch_q);
    // controls are ignored while blanking, so the data mux follows the committed channel there
    assign sel_ch    = (state_q == RUN) ? target : ch_q;
    assign din_sel   = bus.din[int'(sel_ch)*WIDTH +: WIDTH];
    // next-state: blank countdown, switch commit, or steady sampling with dwell tracking
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        blank_d = blank_q;
        ch_d    = ch_q;
        out_d   = out_q;
        valid_d = valid_q;
        sw_d    = 1'b0;
        if (state_q == BLNK) begin
            blank_d = blank_end ? '0 : blank_q + BW'(1);
            state_d = blank_end ? RUN : BLNK;
            out_d   = blank_end ? din_sel : '0;
            valid_d = blank_end;
        end else if (do_sw) begin
            ch_d    = target;
            sw_d    = 1'b1;
            dwell_d = '0;
            blank_d = '0;
            state_d = (BLANK > 0) ? BLNK : RUN;
            out_d   = (BLANK > 0) ? '0 : din_sel;
            valid_d = !(BLANK > 0);
        end else begin
            out_d   = din_sel;
            valid_d = 1'b1;
            dwell_d = !bus.mode ? '0 : bus.hold ? dwell_q : dwell_q + DW'(1);
        end
    end
    // state and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            dwell_q <= '0;
            blank_q <= '0;
            ch_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            blank_q <= blank_d;
            ch_q    <= ch_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            sw_q    <= sw_d;
        end
    end
    assign bus.out      = out_q;
    assign bus.out_ch   = ch_q;
    assign bus.valid    = valid_q;
    assign bus.sw_pulse = sw_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed and randomized checks of mux_scan_reg against a cycle-level reference model
module tb_mux_scan_reg;
    localparam int WIDTH = 8, NCH = 4, SELW = 2, DWELL = 4, BLANK = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    int m_ch, m_left, m_served;
    logic [WIDTH-1:0] m_out;
    logic m_valid, m_sw;
    mux_scan_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();
    mux_scan_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    function automatic logic [WIDTH-1:0] chan(input int c);
        return bus.din[c*WIDTH +: WIDTH];
    endfunction
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_ch = 0; m_left = 0; m_served = 0; m_out = '0; m_valid = 1'b0; m_sw = 1'b0;
    endtask
    // one clock edge of the reference: remaining blank cycles, cycles served on the current channel
    task automatic model_edge();
        int tgt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_sw = 1'b0;
        if (m_left > 0) begin
            m_left--;
            m_out = (m_left == 0) ? chan(m_ch) : 8'h00;
            m_valid = (m_left == 0);
            return;
        end
        if (bus.hold) tgt = m_ch;
        else if (!bus.mode) tgt = (int'(bus.sl) < NCH) ? int'(bus.sl) : NCH - 1;
        else tgt = (m_served == DWELL - 1) ? (m_ch + 1) % NCH : m_ch;
        if (tgt != m_ch) begin
            m_ch = tgt; m_sw = 1'b1; m_served = 0; m_left = BLANK;
            m_out = (BLANK == 0) ? chan(tgt) : 8'h00;
            m_valid = (BLANK == 0);
        end else begin
            m_out = chan(m_ch); m_valid = 1'b1;
            if (!bus.mode) m_served = 0;
            else if (!bus.hold) m_served++;
        end
    endtask
    task automatic check_model();
        cmp("model_out", bus.out, m_out);
        cmp("model_ch", bus.out_ch, m_ch);
        cmp("model_valid", bus.valid, m_valid);
        cmp("model_sw", bus.sw_pulse, m_sw);
    endtask
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_model();
    endtask
    initial begin
        bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.sl = '0; bus.mode = 1'b0; bus.hold = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 cmp("rst_out", bus.out, 8'h00);
        cmp("rst_valid", bus.valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("rst_hold_out", bus.out, 8'h00);
            cmp("rst_hold_valid", bus.valid, 1'b0);
        end
        rst_n = 1'b1;
        step();
        cmp("first_out", bus.out, 8'h11);
        cmp("first_ch", bus.out_ch, 0);
        cmp("first_valid", bus.valid, 1'b1);
        step(); step();
        bus.sl = 2'd2;
        step();
        cmp("man_sw", bus.sw_pulse, 1'b1);
        cmp("man_ch", bus.out_ch, 2);
        cmp("man_out_k", bus.out, 8'h00);
        cmp("man_valid_k", bus.valid, 1'b0);
        step();
        cmp("man_out_k1", bus.out, 8'h00);
        cmp("man_valid_k1", bus.valid, 1'b0);
        step();
        cmp("man_out_k2", bus.out, 8'h33);
        cmp("man_valid_k2", bus.valid, 1'b1);
        bus.sl = 2'd3;
        repeat (3) step();
        cmp("ch3_out", bus.out, 8'h44);
        cmp("ch3_ch", bus.out_ch, 3);
        bus.hold = 1'b1;
        step();
        bus.sl = 2'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            cmp("hold_out", bus.out, 8'h44);
            cmp("hold_sw", bus.sw_pulse, 1'b0);
        end
        bus.hold = 1'b0; bus.mode = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            cmp("scan_sw", bus.sw_pulse, (i % 6) == 4);
            if (i % 6 == 4) cmp("scan_ch", bus.out_ch, i / 6);
            if (i == 6) cmp("wrap_out", bus.out, 8'h11);
        end
        step(); step();
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            cmp("shold_ch", bus.out_ch, 3);
            cmp("shold_sw", bus.sw_pulse, 1'b0);
        end
        bus.hold = 1'b0;
        step();
        cmp("rel_sw_a", bus.sw_pulse, 1'b0);
        step();
        cmp("rel_sw_b", bus.sw_pulse, 1'b1);
        cmp("rel_ch", bus.out_ch, 0);
        step(); step();
        bus.mode = 1'b0; bus.sl = 2'd2;
        step(); step();
        cmp("pre_rst_ch", bus.out_ch, 2);
        async_reset();
        cmp("ar_out", bus.out, 8'h00);
        cmp("ar_ch", bus.out_ch, 0);
        cmp("ar_valid", bus.valid, 1'b0);
        cmp("ar_sw", bus.sw_pulse, 1'b0);
        step();
        bus.sl = 2'd0;
        rst_n = 1'b1;
        step();
        cmp("post_out", bus.out, 8'h11);
        cmp("post_ch", bus.out_ch, 0);
        cmp("post_valid", bus.valid, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) bus.din = $urandom;
            if ($urandom_range(0, 3) == 0) bus.sl = SELW'($urandom);
            if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
            bus.hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
